// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive framing controller (optional error status: UART_RX_STATUS_EN)
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_serial,
  input  logic                  baud_clock_half_cycle_edge,
  input  logic                  baud_clock_full_cycle_edge,
  input  logic                  all_bits_done,
  output logic                  reset_counters,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
`ifdef UART_RX_STATUS_EN
  output logic                  framing_error,
  output logic                  overrun_error,
  input  logic                  status_clear,
`endif
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic                    rx_prev_q;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_done;
  logic                    framing_evt;
  logic                    overrun_evt;

  // Sampling is driven purely by mid-bit strobes; the bit-boundary strobe has no role here.
  logic unused_full_edge;
  assign unused_full_edge = baud_clock_full_cycle_edge;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_serial};
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_done  = 1'b0;
    framing_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (baud_clock_half_cycle_edge) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        // LSB arrives first, so shifting in from the top leaves bit 0 at the LSB.
        if (baud_clock_half_cycle_edge) begin
          shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == BW'(DATA_WIDTH - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_clock_half_cycle_edge) begin
          state_d = ST_IDLE;
          if (rx_s) frame_done  = 1'b1;
          else      framing_evt = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (all_bits_done && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      frame_done  = 1'b0;
      framing_evt = 1'b0;
    end
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_evt = 1'b0;
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_evt = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

`ifdef UART_RX_STATUS_EN
  logic framing_error_q, overrun_error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      framing_error_q <= framing_evt | (framing_error_q & ~status_clear);
      overrun_error_q <= overrun_evt | (overrun_error_q & ~status_clear);
    end
  end

  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;
`else
  logic unused_status;
  assign unused_status = framing_evt | overrun_evt;
`endif

  assign reset_counters = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Receive-side framing controller directly downstream of the baud/bit counter block.
- Consumes the counter's half-cycle, full-cycle and all-bits-done strobes.
- Drives the counter's reset_counters input to align bit timing to each start bit.
- Deserialises one UART frame (1 start, DATA_WIDTH data LSB-first, 1 stop) and presents the byte on a valid/ready holding register.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the counter block's DATA_WIDTH.
- SYNC_STAGES, 2, flops in the rx_serial synchroniser; legal range 2..3.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- rx_serial  input  1  asynchronous serial line, idle high
- baud_clock_half_cycle_edge  input  1  mid-bit strobe from counter
- baud_clock_full_cycle_edge  input  1  bit-boundary strobe from counter
- all_bits_done  input  1  frame-length-elapsed strobe from counter
- reset_counters  output  1  holds counter block cleared while 1
- rx_data  output  DATA_WIDTH  received byte, valid while rx_valid=1
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready
- busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (reset=0, async): state=IDLE, reset_counters=1, rx_data=0, rx_valid=0, busy=0; synchroniser flops and line-history flop=1.
- rx_serial passes through SYNC_STAGES flops; all decisions use the synchronised value rx_s; rx_prev = rx_s delayed one clock.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: reset_counters=1. On rx_prev=1 && rx_s=0 (falling edge) -> START, reset_counters=0 from the next cycle. A line held low never retriggers.
- START: on half edge, rx_s=0 -> DATA with bit_idx=0; rx_s=1 -> IDLE (glitch rejected, nothing reported).
- DATA: on each half edge, shift_reg[bit_idx]<=rx_s, bit_idx++. After bit DATA_WIDTH-1 -> STOP.
- STOP: on half edge, rx_s=1 -> deliver frame, then IDLE. rx_s=0 -> framing error, frame discarded, IDLE.
- full_cycle_edge is ignored for sampling; sampling uses mid-bit (half) strobes only.
- Safety abort: all_bits_done=1 in any state other than IDLE -> IDLE, frame discarded.
- Delivery: rx_data/rx_valid update the cycle after the stop-bit half edge. Frame completes while rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle -> rx_data<=shift_reg, rx_valid=1.
- Overrun: frame completes while rx_valid=1 and rx_ready=0 -> new byte dropped; old rx_data kept unchanged.
- rx_valid && rx_ready with no completion -> rx_valid=0 next cycle; rx_data holds its last value.
- bit_idx width is $clog2(DATA_WIDTH)+1; no wrap-around inside a frame.
- Reset mid-frame: immediate return to reset values; partial byte is lost.

Optional Feature:
- Macro: UART_RX_STATUS_EN.
- Defined: adds output framing_error (1 bit), output overrun_error (1 bit) and input status_clear (1 bit). Both error flags are sticky, reset to 0, set on their event (stop bit=0, or overrun drop), and cleared by status_clear=1. When set and clear occur in the same cycle, set wins.
- Not defined: these ports are absent; errored frames are silently discarded.

Test Plan (bench counter BAUD_COUNT=16, DATA_WIDTH=8):
- Idle line, then frame 0xA5 with stop=1 -> reset_counters falls 1 clock after the synchronised edge; rx_valid=1 with rx_data=0xA5 one clock after the stop-bit half edge; busy=0 afterwards.
- 3-clock low glitch on idle line -> START returns to IDLE at the half edge; rx_valid stays 0; reset_counters back to 1.
- Frame 0x3C with stop=0 -> rx_valid stays 0; with UART_RX_STATUS_EN, framing_error=1 until status_clear pulse.
- Frames 0x11 then 0x22 with rx_ready=0 throughout -> rx_data=0x11 retained, rx_valid=1; overrun_error=1 if enabled. Then pulse rx_ready -> rx_valid=0.
- rx_ready=1 in exactly the delivery cycle of frame 0x22 while 0x11 is pending -> 0x11 consumed, rx_data=0x22, rx_valid stays 1.
- reset=0 asserted during data bit 4 of frame 0xFF -> all outputs return to reset values immediately; the next clean frame 0x0F is received correctly.
